// File: rtl/sweep_pkg.sv
// Shared types and step arithmetic for the frequency-sweep controller.
package sweep_pkg;

    localparam int PW_DEF = 8;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Operands are zero-extended PW-bit values (PW <= 32); the 33-bit sum keeps
    // the carry out, so an overshoot past stop clamps back to stop.
    function automatic logic [31:0] next_step(input logic [31:0] step,
                                              input logic [31:0] inc,
                                              input logic [31:0] stop,
                                              input logic        up);
        logic [32:0] sum;
        if (up) begin
            sum = {1'b0, step} + {1'b0, inc};
            return (sum > {1'b0, stop}) ? stop : sum[31:0];
        end
        sum = {1'b0, stop} + {1'b0, inc};
        return ({1'b0, step} < sum) ? stop : step - inc;
    endfunction

endpackage

// File: rtl/sweep_ctrl_dwell.sv
// Dwell counter: flags the last cycle of each step hold; a zero limit acts as 1.
module dwell_counter #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] limit,
    output logic          tc
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] last;

    assign last = (limit == '0) ? '0 : limit - DW'(1);
    assign tc   = en && (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tc ? '0 : cnt_q + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep controller: ramps the accumulator step from start to stop,
// holding each value for a programmable dwell, in single or continuous mode.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_init_phase,
    input  logic [PW-1:0] cfg_step_start,
    input  logic [PW-1:0] cfg_step_stop,
    input  logic [PW-1:0] cfg_step_inc,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_cont,
    input  logic          start,
    input  logic          abort,
    output logic          pc_en,
    output logic [PW-1:0] pc_init_phase,
    output logic [PW-1:0] pc_step,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [PW-1:0] init_q, start_q, stop_q, inc_q;
    logic [DW-1:0] dwell_q;
    logic          cont_q, up_q;
    logic [PW-1:0] step_q, step_d;
    logic          hs, tc, last_step;

    assign hs        = cfg_valid && (state_q == S_IDLE);
    assign last_step = (step_q == stop_q) || (inc_q == '0);

    dwell_counter #(.DW(DW)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q != S_RUN),
        .en    (state_q == S_RUN),
        .limit (dwell_q),
        .tc    (tc)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRIME;
                    // A same-cycle handshake wins: take the start value straight off the bus.
                    step_d  = hs ? cfg_step_start : start_q;
                end
            end
            S_PRIME: begin
                state_d = S_RUN;
                step_d  = start_q;
            end
            S_RUN: begin
                if (tc) begin
                    if (!last_step)
                        step_d = PW'(next_step(32'(step_q), 32'(inc_q), 32'(stop_q), up_q));
                    else if (cont_q)
                        step_d = start_q;
                    else
                        state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            step_d  = step_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            init_q  <= '0;
            start_q <= '0;
            stop_q  <= '0;
            inc_q   <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (hs) begin
                init_q  <= cfg_init_phase;
                start_q <= cfg_step_start;
                stop_q  <= cfg_step_stop;
                inc_q   <= cfg_step_inc;
                dwell_q <= cfg_dwell;
                cont_q  <= cfg_cont;
                up_q    <= (cfg_step_stop >= cfg_step_start);
            end
        end
    end

    assign cfg_ready     = (state_q == S_IDLE);
    assign pc_en         = (state_q == S_RUN);
    assign busy          = (state_q == S_PRIME) || (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign pc_step       = step_q;
    assign pc_init_phase = init_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: directed and random sweeps against an
// integer model of the step sequence.
module tb_sweep_ctrl;

    localparam int PW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [PW-1:0] cfg_init_phase = '0;
    logic [PW-1:0] cfg_step_start = '0;
    logic [PW-1:0] cfg_step_stop = '0;
    logic [PW-1:0] cfg_step_inc = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          cfg_cont = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pc_en;
    logic [PW-1:0] pc_init_phase;
    logic [PW-1:0] pc_step;
    logic          busy;
    logic          done;

    sweep_ctrl #(.PW(PW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_init_phase(cfg_init_phase), .cfg_step_start(cfg_step_start),
        .cfg_step_stop(cfg_step_stop), .cfg_step_inc(cfg_step_inc),
        .cfg_dwell(cfg_dwell), .cfg_cont(cfg_cont),
        .start(start), .abort(abort),
        .pc_en(pc_en), .pc_init_phase(pc_init_phase), .pc_step(pc_step),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int seq[$];

    logic [11:0] obs;
    assign obs = {cfg_ready, busy, pc_en, done, pc_step};

    // Expected step value for every RUN cycle of a single sweep.
    task automatic build_seq(input int s, input int e, input int inc, input int dw);
        int v;
        int d;
        seq.delete();
        v = s;
        d = (dw == 0) ? 1 : dw;
        while (1) begin
            for (int r = 0; r < d; r++) seq.push_back(v);
            if (v == e || inc == 0) break;
            if (e >= s) v = (v + inc > e) ? e : v + inc;
            else        v = (v - inc < e) ? e : v - inc;
        end
    endtask

    task automatic drive_cfg(input int init, input int s, input int e, input int inc,
                             input int dw, input logic cont);
        cfg_init_phase = PW'(init);
        cfg_step_start = PW'(s);
        cfg_step_stop  = PW'(e);
        cfg_step_inc   = PW'(inc);
        cfg_dwell      = DW'(dw);
        cfg_cont       = cont;
        cfg_valid      = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (obs !== {4'b1000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_outputs got %h exp %h", obs, {4'b1000, 8'h00});
        end
        n_cmp++;
        if (pc_init_phase !== 8'h00) begin
            n_err++;
            $display("FAIL reset_init_phase got %h exp 00", pc_init_phase);
        end
    endtask

    task automatic test_single_sweeps();
        int tab[7][5] = '{
            '{16,   4,  12,   4, 3},
            '{ 0, 200,   5, 100, 1},
            '{ 0, 250, 255,  10, 1},
            '{ 3,   3,   9,   2, 0},
            '{ 0,   7,   9,   0, 2},
            '{ 9,  33,  33,   5, 2},
            '{ 0,   9,   2,   3, 1}
        };
        int init, s, e, inc, dw;
        logic [11:0] ex;
        for (int k = 0; k < 27; k++) begin
            if (k < 7) begin
                init = tab[k][0]; s = tab[k][1]; e = tab[k][2]; inc = tab[k][3]; dw = tab[k][4];
            end else begin
                init = $urandom_range(0, 255);
                s    = $urandom_range(0, 255);
                e    = $urandom_range(0, 255);
                inc  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(1, 40);
                dw   = $urandom_range(0, 3);
            end
            build_seq(s, e, inc, dw);
            drive_cfg(init, s, e, inc, dw, 1'b0);
            start = 1'b1;
            @(negedge clk);
            cfg_valid = 1'b0;
            start     = 1'b0;
            ex = {4'b0100, 8'(s)};
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL sweep%0d prime got %h exp %h", k, obs, ex);
            end
            n_cmp++;
            if (pc_init_phase !== 8'(init)) begin
                n_err++;
                $display("FAIL sweep%0d init_phase got %h exp %h", k, pc_init_phase, 8'(init));
            end
            for (int i = 0; i < seq.size(); i++) begin
                @(negedge clk);
                ex = {4'b0110, 8'(seq[i])};
                n_cmp++;
                if (obs !== ex) begin
                    n_err++;
                    $display("FAIL sweep%0d run[%0d] got %h exp %h", k, i, obs, ex);
                end
            end
            @(negedge clk);
            n_cmp++;
            if (obs[11:8] !== 4'b0001 || (seq[$] == e && pc_step !== 8'(e))) begin
                n_err++;
                $display("FAIL sweep%0d done_cycle got %h exp 1%h", k, obs, 8'(e));
            end
            @(negedge clk);
            n_cmp++;
            if (obs[11:8] !== 4'b1000) begin
                n_err++;
                $display("FAIL sweep%0d idle_return got %h exp 8", k, obs[11:8]);
            end
        end
    endtask

    task automatic test_continuous();
        logic [11:0] ex;
        drive_cfg(5, 1, 3, 1, 2, 1'b1);
        start = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        n_cmp++;
        if (obs !== {4'b0100, 8'd1}) begin
            n_err++;
            $display("FAIL cont_prime got %h exp %h", obs, {4'b0100, 8'd1});
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            ex = {4'b0110, 8'(1 + (i / 2) % 3)};
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL cont_run[%0d] got %h exp %h", i, obs, ex);
            end
            // Offer a new config and a start mid-run; both must be ignored.
            if (i == 9) drive_cfg(0, 100, 120, 7, 1, 1'b0);
            if (i == 11) start = 1'b1;
            if (i == 13) begin cfg_valid = 1'b0; start = 1'b0; end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (obs[11:8] !== 4'b1000) begin
            n_err++;
            $display("FAIL cont_abort got %h exp 8", obs[11:8]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs[11:8] !== 4'b1000) begin
                n_err++;
                $display("FAIL abort_no_done[%0d] got %h exp 8", i, obs[11:8]);
            end
        end
        // Restart without a handshake: the stalled config must not have landed.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (obs !== {4'b0100, 8'd1} || pc_init_phase !== 8'd5) begin
            n_err++;
            $display("FAIL cfg_kept_prime got %h/%h exp %h/05", obs, pc_init_phase, {4'b0100, 8'd1});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ex = {4'b0110, 8'(1 + (i / 2) % 3)};
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL cfg_kept_run[%0d] got %h exp %h", i, obs, ex);
            end
        end
        abort = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (obs[11:8] !== 4'b1000) begin
            n_err++;
            $display("FAIL abort_with_start got %h exp 8", obs[11:8]);
        end
    endtask

    task automatic test_rst_mid_run();
        logic [11:0] ex[4] = '{{4'b0100, 8'd0}, {4'b0110, 8'd0}, {4'b0001, 8'd0}, {4'b1000, 8'd0}};
        drive_cfg(77, 10, 200, 1, 5, 1'b0);
        start = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (obs !== {4'b1000, 8'd0} || pc_init_phase !== 8'd0) begin
            n_err++;
            $display("FAIL rst_mid_run got %h/%h exp 800/00", obs, pc_init_phase);
        end
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL rst_cfg_sweep[%0d] got %h exp %h", i, obs, ex[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_sweeps();
        test_continuous();
        test_rst_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
